// File: rtl/sram_mem_ctrl.sv
// Memory-stage SRAM controller: stalls the pipeline while a fixed-latency SRAM access runs.
// Optional MEM_ALIGN_CHECK_EN adds align_err and short-circuits misaligned requests.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_we_n,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        sram_oe_n,
    output logic        align_err
`else
    output logic        sram_oe_n
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        op_wr;
    logic        start;
    logic        capture;
    logic        misalign;
    logic [31:0] offset;
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        ready     = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        misalign  = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        unique case (state)
            IDLE: begin
                ready = !(wr_en || rd_en);
                if (wr_en || rd_en) begin
                    start = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    if (address[1:0] != 2'b00) begin
                        misalign = 1'b1;
                        next     = DONE;
                    end else begin
                        next = ACCESS;
                    end
`else
                    next = ACCESS;
`endif
                end
            end
            ACCESS: begin
                sram_we_n = !op_wr;
                sram_oe_n = op_wr;
                if (cnt == LAST_CNT) begin
                    next    = DONE;
                    capture = !op_wr;
                end
            end
            DONE: begin
                // Enables are still high here; they must not retrigger.
                ready = 1'b1;
                next  = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            op_wr     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            if (start) begin
                cnt    <= 4'd0;
                addr_q <= address;
                data_q <= write_data;
                op_wr  <= wr_en;
            end else if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
            end
            if (capture) begin
                read_data <= sram_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else begin
            align_err <= misalign;
        end
    end
`endif

    // Offset wraps modulo 2^32; only the word bits inside 1 MiB reach the SRAM.
    assign offset      = addr_q - BASE_ADDR;
    assign sram_addr   = offset[19:2];
    assign sram_wdata  = data_q;
    assign unused_bits = ^{offset[31:20], offset[1:0], misalign};

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 5, number of ACCESS cycles per SRAM transaction (legal 1..15).
REQ-002 Parameter BASE_ADDR, default 1024, byte address that maps to SRAM word 0.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  memory-stage store request.
REQ-006 rd_en  in  1  memory-stage load request.
REQ-007 address  in  32  byte address from the ALU result.
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  registered load result.
REQ-010 ready  out  1  high when the pipeline may advance; low freezes the pipeline.
REQ-011 sram_addr  out  18  SRAM word address.
REQ-012 sram_wdata  out  32  SRAM write data.
REQ-013 sram_rdata  in  32  SRAM read data.
REQ-014 sram_we_n  out  1  SRAM write strobe, active low.
REQ-015 sram_oe_n  out  1  SRAM output enable, active low.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; a 4-bit wait counter.
REQ-017 IDLE: on wr_en or rd_en high, latch address, write_data and op (write wins if both are high), clear the counter, and go to ACCESS.
REQ-018 ACCESS: increment the counter each cycle; after WAIT_CYCLES cycles in ACCESS, go to DONE.
REQ-019 On the last ACCESS cycle of a read, capture sram_rdata into read_data.
REQ-020 DONE: go to IDLE unconditionally; the still-asserted enables in DONE do not start a new transaction.
REQ-021 ready = (IDLE and neither enable high) or DONE; it is combinational from state and enables.
REQ-022 A transaction holds ready low for exactly WAIT_CYCLES+1 cycles, then high for one DONE cycle.
REQ-023 sram_addr = latched (address - BASE_ADDR) bits [19:2]; result is 32-bit modulo, and bits above 19 are dropped (wrap-around).
REQ-024 sram_we_n is low only in ACCESS during a write; sram_oe_n is low only in ACCESS during a read; otherwise both are high.
REQ-025 sram_wdata is the latched write_data.
REQ-026 read_data holds its value until the next completed read; writes do not alter it.

Reset
REQ-027 On rst: state IDLE, counter 0, read_data 0, latched address and data 0, sram_we_n 1, sram_oe_n 1.
REQ-028 Reset during ACCESS aborts the transaction; strobes are high from the next edge and read_data is zeroed.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN: when defined, add output align_err (1 bit, reset 0).
REQ-030 With MEM_ALIGN_CHECK_EN defined, a request in IDLE with address[1:0] != 0:
  - sets align_err for one cycle;
  - skips ACCESS and goes directly to DONE with no SRAM strobe.
REQ-031 Without MEM_ALIGN_CHECK_EN, align_err does not exist and address[1:0] is ignored.

Verification
REQ-032 Write with WAIT_CYCLES=5, address=1028, data 0xDEADBEEF:
  - sram_addr=1 and sram_we_n low for 5 cycles;
  - ready low 6 cycles, then high 1 cycle.
REQ-033 Read from 1028 after REQ-032, with the SRAM model returning the stored word: read_data=0xDEADBEEF in the DONE cycle; sram_oe_n low 5 cycles.
REQ-034 Back-to-back read then write with enables held through DONE: exactly two transactions, no duplicate, IDLE seen for 1 cycle between them.
REQ-035 wr_en and rd_en both high at address 1032: a write occurs, sram_oe_n stays high, and read_data is unchanged.
REQ-036 rst asserted in the 3rd ACCESS cycle: the next edge gives state IDLE, sram_we_n=1, read_data=0, and ready=1 with no request.
REQ-037 MEM_ALIGN_CHECK_EN defined, read at 1030: align_err=1 for one cycle, no SRAM strobe, and ready high on the second cycle.
